// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up/down counter with clear/load and a multiplexed digit scanner.
// The scanned digit nibble and the active-low one-hot select are registered together.
module bcd_scan_counter #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cnt_en,
  input  logic        up_dn,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        blank,
  output logic [15:0] bcd_val,
  output logic [3:0]  digit_out,
  output logic [3:0]  digit_sel,
  output logic        carry
);

  localparam logic [15:0] DivLast = 16'(SCAN_DIV - 1);

  logic [15:0] bcd_q, bcd_d;
  logic        carry_q, carry_d;
  logic [15:0] div_q, div_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  digit_out_q, digit_out_d;
  logic [3:0]  digit_sel_q, digit_sel_d;
  logic        ripple;
  logic [3:0]  nib;

  // Count value: clear > load > cnt_en, decimal ripple resolved within one cycle.
  always_comb begin
    bcd_d   = bcd_q;
    carry_d = 1'b0;
    ripple  = 1'b0;
    nib     = 4'h0;
    if (clear) begin
      bcd_d = '0;
    end else if (load) begin
      for (int i = 0; i < 4; i++) begin
        nib               = load_val[4*i +: 4];
        bcd_d[4*i +: 4]   = (nib > 4'd9) ? 4'd9 : nib;
      end
    end else if (cnt_en) begin
      ripple = 1'b1;
      for (int i = 0; i < 4; i++) begin
        nib = bcd_q[4*i +: 4];
        if (ripple) begin
          if (up_dn) begin
            if (nib >= 4'd9) begin
              bcd_d[4*i +: 4] = 4'd0;
            end else begin
              bcd_d[4*i +: 4] = nib + 4'd1;
              ripple          = 1'b0;
            end
          end else begin
            if (nib == 4'd0) begin
              bcd_d[4*i +: 4] = 4'd9;
            end else begin
              bcd_d[4*i +: 4] = nib - 4'd1;
              ripple          = 1'b0;
            end
          end
        end
      end
      // A ripple surviving all four digits is the full wrap.
      carry_d = ripple;
    end
  end

  // Free-running scan divider and digit index.
  always_comb begin
    div_d = div_q + 16'd1;
    idx_d = idx_q;
    if (div_q >= DivLast) begin
      div_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Nibble and select both come from next-state values so they change together.
  always_comb begin
    digit_out_d = 4'h0;
    case (idx_d)
      2'd0:    digit_out_d = bcd_d[3:0];
      2'd1:    digit_out_d = bcd_d[7:4];
      2'd2:    digit_out_d = bcd_d[11:8];
      default: digit_out_d = bcd_d[15:12];
    endcase
    digit_sel_d = blank ? 4'b1111 : ~(4'b0001 << idx_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcd_q       <= '0;
      carry_q     <= 1'b0;
      div_q       <= '0;
      idx_q       <= '0;
      digit_out_q <= 4'h0;
      digit_sel_q <= 4'b1110;
    end else begin
      bcd_q       <= bcd_d;
      carry_q     <= carry_d;
      div_q       <= div_d;
      idx_q       <= idx_d;
      digit_out_q <= digit_out_d;
      digit_sel_q <= digit_sel_d;
    end
  end

  assign bcd_val   = bcd_q;
  assign carry     = carry_q;
  assign digit_out = digit_out_q;
  assign digit_sel = digit_sel_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Self-checking bench for bcd_scan_counter: vector table plus scan/blank/reset sequences,
// with expected outputs queued at drive time and compared after each edge.
module tb_bcd_scan_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cnt_en = 1'b0;
  logic        up_dn = 1'b0;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = 16'h0;
  logic        blank = 1'b0;
  logic [15:0] bcd_val;
  logic [3:0]  digit_out;
  logic [3:0]  digit_sel;
  logic        carry;

  always #5 clk = ~clk;

  bcd_scan_counter #(.SCAN_DIV(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cnt_en   (cnt_en),
    .up_dn    (up_dn),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .blank    (blank),
    .bcd_val  (bcd_val),
    .digit_out(digit_out),
    .digit_sel(digit_sel),
    .carry    (carry)
  );

  typedef struct {
    logic [15:0] bcd;
    logic        carry;
    logic [3:0]  sel;
    logic [3:0]  dout;
  } exp_t;

  typedef struct {
    logic        cl, ld, en, ud;
    logic [15:0] lv;
    logic [15:0] bcd;
    logic        c;
  } vec_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   div_m = 0;
  int   idx_m = 0;
  vec_t vecs[18];

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  task automatic step(input logic rn, cl, ld, en, ud, bl, input logic [15:0] lv,
                      input logic [15:0] eb, input logic ec);
    exp_t        e;
    exp_t        got;
    logic [3:0]  one;
    logic [15:0] sh;
    rst_n = rn; clear = cl; load = ld; cnt_en = en; up_dn = ud; blank = bl; load_val = lv;
    if (!rn) begin
      div_m = 0;
      idx_m = 0;
    end else if (div_m == 3) begin
      div_m = 0;
      idx_m = (idx_m + 1) % 4;
    end else begin
      div_m++;
    end
    one     = 4'b0001;
    e.bcd   = rn ? eb : 16'h0;
    e.carry = rn ? ec : 1'b0;
    e.sel   = !rn ? 4'b1110 : (bl ? 4'b1111 : ~(one << idx_m));
    sh      = e.bcd >> (4 * idx_m);
    e.dout  = !rn ? 4'h0 : sh[3:0];
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check("bcd_val",   bcd_val,                 got.bcd);
    check("carry",     {15'h0, carry},          {15'h0, got.carry});
    check("digit_sel", {12'h0, digit_sel},      {12'h0, got.sel});
    check("digit_out", {12'h0, digit_out},      {12'h0, got.dout});
  endtask

  task automatic idle(input int n, input logic bl, input logic [15:0] eb);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, bl, 16'h0, eb, 0);
  endtask

  initial begin
    int guard;
    //           cl  ld  en  ud  load_val  bcd       c
    vecs[0]  = '{0,  1,  0,  0,  16'h0A5F, 16'h0959, 0};
    vecs[1]  = '{0,  0,  1,  1,  16'h0000, 16'h0960, 0};
    vecs[2]  = '{0,  0,  1,  0,  16'h0000, 16'h0959, 0};
    vecs[3]  = '{0,  1,  0,  0,  16'h9999, 16'h9999, 0};
    vecs[4]  = '{0,  0,  1,  1,  16'h0000, 16'h0000, 1};
    vecs[5]  = '{0,  0,  0,  1,  16'h0000, 16'h0000, 0};
    vecs[6]  = '{0,  0,  1,  0,  16'h0000, 16'h9999, 1};
    vecs[7]  = '{0,  0,  0,  0,  16'h0000, 16'h9999, 0};
    vecs[8]  = '{1,  1,  1,  1,  16'h1234, 16'h0000, 0};
    vecs[9]  = '{0,  1,  1,  1,  16'h0199, 16'h0199, 0};
    vecs[10] = '{0,  0,  1,  1,  16'h0000, 16'h0200, 0};
    vecs[11] = '{0,  0,  1,  0,  16'h0000, 16'h0199, 0};
    vecs[12] = '{0,  1,  0,  0,  16'h1000, 16'h1000, 0};
    vecs[13] = '{0,  0,  1,  0,  16'h0000, 16'h0999, 0};
    vecs[14] = '{0,  1,  0,  0,  16'hFFFF, 16'h9999, 0};
    vecs[15] = '{1,  0,  0,  0,  16'h0000, 16'h0000, 0};
    vecs[16] = '{0,  0,  0,  1,  16'h0000, 16'h0000, 0};
    vecs[17] = '{0,  1,  0,  0,  16'hA3B7, 16'h9397, 0};

    // Reset, then twelve up steps from zero.
    step(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0);
    for (int i = 0; i < 12; i++) step(1, 0, 0, 1, 1, 0, 16'h0, to_bcd(i + 1), 0);

    for (int i = 0; i < 18; i++)
      step(1, vecs[i].cl, vecs[i].ld, vecs[i].en, vecs[i].ud, 0, vecs[i].lv,
           vecs[i].bcd, vecs[i].c);

    // Scan alignment from reset with a fixed value, then a mid-slot count change.
    step(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0);
    step(1, 0, 1, 0, 0, 0, 16'h4321, 16'h4321, 0);
    idle(20, 0, 16'h4321);
    step(1, 0, 0, 1, 1, 0, 16'h0, 16'h4322, 0);
    idle(3, 0, 16'h4322);

    // Blanking must not stall the scan.
    idle(10, 1, 16'h4322);
    idle(8, 0, 16'h4322);

    // Reset while digit 2 is selected, then a full period on digit 0.
    guard = 0;
    while (idx_m != 2 && guard < 20) begin
      idle(1, 0, 16'h4322);
      guard++;
    end
    check("reach_digit2", 16'(idx_m), 16'd2);
    step(0, 0, 0, 1, 1, 0, 16'h0, 16'h0, 0);
    idle(6, 0, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_scan_counter.md
BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

Interface
REQ-001 Parameter SCAN_DIV, default 1000, sets the number of clk cycles each digit stays selected; legal range 2..65535.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 cnt_en  input  1  count request, one step per cycle while high.
REQ-005 up_dn  input  1  1 = count up, 0 = count down; sampled with cnt_en.
REQ-006 clear  input  1  synchronous clear of count value.
REQ-007 load  input  1  synchronous load of load_val.
REQ-008 load_val  input  16  four BCD digits, [3:0] = digit 0 (least significant).
REQ-009 blank  input  1  1 = all digits deselected.
REQ-010 bcd_val  output  16  current registered four-digit BCD count.
REQ-011 digit_out  output  4  BCD nibble of the currently scanned digit; drives the 4-bit Din of the binary-to-segment decoder.
REQ-012 digit_sel  output  4  active-low one-hot digit enable; bit n low means digit n is lit.
REQ-013 carry  output  1  one-cycle pulse on 9999->0000 up-wrap or 0000->9999 down-wrap.

Function
REQ-014 Priority SHALL be clear > load > cnt_en; the lower-priority requests in the same cycle are ignored.
REQ-015 clear SHALL set bcd_val to 16'h0000 on the next edge with carry = 0.
REQ-016 load SHALL copy load_val into bcd_val; any nibble > 9 SHALL be stored as 9; carry = 0.
REQ-017 cnt_en with up_dn = 1 SHALL increment bcd_val by one in decimal; a digit at 9 SHALL become 0 and ripple +1 into the next digit within the same cycle.
REQ-018 cnt_en with up_dn = 0 SHALL decrement in decimal; a digit at 0 SHALL become 9 and ripple borrow within the same cycle.
REQ-019 Up from 9999 SHALL give 0000 and down from 0000 SHALL give 9999; carry SHALL be high for exactly the cycle after that edge.
REQ-020 The count update latency SHALL be one cycle: bcd_val reflects a request on the edge it is sampled.
REQ-021 The scan divider SHALL count 0..SCAN_DIV-1 continuously and independently of counting, clear and load.
REQ-022 At divider terminal count, the digit index SHALL advance 0->1->2->3->0 on the same edge the divider returns to 0.
REQ-023 digit_sel SHALL be ~(1 << index) when blank = 0, and 4'b1111 when blank = 1; blank SHALL NOT stop the scan.
REQ-024 digit_out SHALL be registered and SHALL equal bcd_val nibble[index], both taken from their values after the same edge, so digit_sel and digit_out never disagree for a cycle.
REQ-025 A count change mid-scan SHALL appear on digit_out within one cycle, without waiting for the next digit slot.
REQ-026 At most one digit_sel bit SHALL be low in any cycle.

Reset
REQ-027 With rst_n = 0 at a rising edge, the block SHALL set bcd_val = 0, index = 0, divider = 0, digit_out = 0, digit_sel = 4'b1110 and carry = 0, overriding all other inputs.
REQ-028 Reset asserted mid-count or mid-scan SHALL take effect on that edge; the first divider period after release SHALL be a full SCAN_DIV cycles on digit 0.

Verification
REQ-029 Reset, then 12 cycles of cnt_en = 1, up_dn = 1 -> bcd_val = 16'h0012, carry never high.
REQ-030 load = 1 with load_val = 16'h9999, then one up step -> bcd_val = 16'h0000 and carry high for exactly one cycle; a down step from 0000 -> 16'h9999 with a carry pulse.
REQ-031 load_val = 16'h0A5F -> bcd_val = 16'h0959; clear, load and cnt_en all high in one cycle -> bcd_val = 16'h0000.
REQ-032 SCAN_DIV = 4, bcd_val = 16'h4321 -> digit_sel sequence 1110/1101/1011/0111, 4 cycles each, with digit_out 1/2/3/4 aligned to the matching digit_sel.
REQ-033 blank = 1 for 10 cycles -> digit_sel = 4'b1111 throughout; when blank returns to 0, digit_sel is at the same point in the scan as an unblanked run.
REQ-034 rst_n = 0 for one edge while on digit 2 with a nonzero count -> next cycle bcd_val = 0, digit_sel = 4'b1110, digit_out = 0, carry = 0.
